reg_writeback: RTL and testbench

Write-side front end of the 32x32 register file: arbitrates results from the single-cycle ALU path and the variable-latency load/store unit (LSU) onto the register file's single write port. Buffers LSU results in a small FIFO and keeps a per-register pending scoreboard so decode can stall on outstanding loads. Sits between the execute/memory stages and the register file write inputs.

---
 rtl/reg_writeback.sv | 128 ++++++++++++
 tb/tb_reg_writeback.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Write-port front end of the register file: merges ALU and buffered LSU results
// onto one registered write port and tracks registers with outstanding loads.
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        WB_alu_valid,
    input  logic [4:0]  WB_alu_rd,
    input  logic [31:0] WB_alu_data,
    input  logic        WB_lsu_valid,
    output logic        WB_lsu_ready,
    input  logic [4:0]  WB_lsu_rd,
    input  logic [31:0] WB_lsu_data,
    input  logic        WB_issue_valid,
    input  logic [4:0]  WB_issue_rd,
    input  logic [4:0]  WB_check_addr1,
    input  logic [4:0]  WB_check_addr2,
    output logic        WB_busy1,
    output logic        WB_busy2,
    output logic        REG_write_1,
    output logic [4:0]  REG_address_wr,
    output logic [31:0] REG_data_wb_in1
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]    r_fifo_rd   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pending;
    logic          r_src_lsu;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_sel_valid;
    logic          w_sel_lsu;
    logic [4:0]    w_sel_rd;
    logic [31:0]   w_sel_data;
    logic [31:0]   w_pending_next;

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign WB_lsu_ready = reset_n && !w_full;
    assign w_push       = WB_lsu_valid && WB_lsu_ready;
    assign w_pop        = !WB_alu_valid && !w_empty;

    // ALU has absolute priority; the FIFO head is used only on ALU-idle cycles.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_lsu   = 1'b0;
        w_sel_rd    = 5'd0;
        w_sel_data  = 32'd0;
        if (WB_alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = WB_alu_rd;
            w_sel_data  = WB_alu_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_lsu   = 1'b1;
            w_sel_rd    = r_fifo_rd[r_rptr];
            w_sel_data  = r_fifo_data[r_rptr];
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= WB_lsu_rd;
            r_fifo_data[r_wptr] <= WB_lsu_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            REG_write_1     <= 1'b0;
            REG_address_wr  <= 5'd0;
            REG_data_wb_in1 <= 32'd0;
            r_src_lsu       <= 1'b0;
        end else begin
            REG_write_1 <= w_sel_valid && (w_sel_rd != 5'd0);
            r_src_lsu   <= w_sel_lsu;
            if (w_sel_valid) begin
                REG_address_wr  <= w_sel_rd;
                REG_data_wb_in1 <= w_sel_data;
            end
        end
    end

    // Clear first, then set, so a new issue racing a committing load stays pending.
    always_comb begin
        w_pending_next = r_pending;
        if (REG_write_1 && r_src_lsu)
            w_pending_next[REG_address_wr] = 1'b0;
        if (WB_issue_valid && (WB_issue_rd != 5'd0))
            w_pending_next[WB_issue_rd] = 1'b1;
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_pending <= 32'd0;
        else          r_pending <= w_pending_next;
    end

    assign WB_busy1 = (WB_check_addr1 != 5'd0) && r_pending[WB_check_addr1];
    assign WB_busy2 = (WB_check_addr2 != 5'd0) && r_pending[WB_check_addr2];

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised and directed bench for reg_writeback with a queue-based reference
// model and a scoreboard monitor on the register-file write port.
module tb_reg_writeback;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        WB_alu_valid = 1'b0;
    logic [4:0]  WB_alu_rd = '0;
    logic [31:0] WB_alu_data = '0;
    logic        WB_lsu_valid = 1'b0;
    logic        WB_lsu_ready;
    logic [4:0]  WB_lsu_rd = '0;
    logic [31:0] WB_lsu_data = '0;
    logic        WB_issue_valid = 1'b0;
    logic [4:0]  WB_issue_rd = '0;
    logic [4:0]  WB_check_addr1 = '0;
    logic [4:0]  WB_check_addr2 = '0;
    logic        WB_busy1;
    logic        WB_busy2;
    logic        REG_write_1;
    logic [4:0]  REG_address_wr;
    logic [31:0] REG_data_wb_in1;

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .WB_alu_valid(WB_alu_valid), .WB_alu_rd(WB_alu_rd), .WB_alu_data(WB_alu_data),
        .WB_lsu_valid(WB_lsu_valid), .WB_lsu_ready(WB_lsu_ready),
        .WB_lsu_rd(WB_lsu_rd), .WB_lsu_data(WB_lsu_data),
        .WB_issue_valid(WB_issue_valid), .WB_issue_rd(WB_issue_rd),
        .WB_check_addr1(WB_check_addr1), .WB_check_addr2(WB_check_addr2),
        .WB_busy1(WB_busy1), .WB_busy2(WB_busy2),
        .REG_write_1(REG_write_1), .REG_address_wr(REG_address_wr),
        .REG_data_wb_in1(REG_data_wb_in1)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [36:0] mq[$];     // buffered LSU results {rd,data}
    logic [36:0] expq[$];   // register-file writes still to appear
    bit          pend[32];
    bit          m_we;
    bit          m_src_lsu;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        expq.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        m_we = 1'b0;
        m_src_lsu = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    always @(negedge clock) begin
        if (REG_write_1) begin
            if (expq.size() == 0) begin
                chk("unexpected_write", {27'd0, REG_address_wr, REG_data_wb_in1}, 64'd0);
            end else begin
                logic [36:0] e;
                e = expq.pop_front();
                chk("write_addr", {59'd0, REG_address_wr}, {59'd0, e[36:32]});
                chk("write_data", {32'd0, REG_data_wb_in1}, {32'd0, e[31:0]});
            end
        end
    end

    // One clock cycle: called just after a rising edge, returns after the next one.
    task automatic cyc(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ir,
                       input logic [4:0] c1, input logic [4:0] c2, output bit acc);
        bit          sv, slsu, rdy;
        logic [4:0]  srd;
        logic [31:0] sd;
        logic [36:0] e;
        #1;
        WB_alu_valid = av;   WB_alu_rd = ar;   WB_alu_data = ad;
        WB_lsu_valid = lv;   WB_lsu_rd = lr;   WB_lsu_data = ld;
        WB_issue_valid = iv; WB_issue_rd = ir;
        WB_check_addr1 = c1; WB_check_addr2 = c2;
        #1;
        rdy = (mq.size() < DEPTH);
        chk("lsu_ready", {63'd0, WB_lsu_ready}, {63'd0, rdy});
        chk("busy1", {63'd0, WB_busy1}, {63'd0, (c1 != 0) && pend[c1]});
        chk("busy2", {63'd0, WB_busy2}, {63'd0, (c2 != 0) && pend[c2]});
        chk("out_we", {63'd0, REG_write_1}, {63'd0, m_we});
        chk("out_addr_hold", {59'd0, REG_address_wr}, {59'd0, m_addr});
        chk("out_data_hold", {32'd0, REG_data_wb_in1}, {32'd0, m_data});
        sv = 1'b0; slsu = 1'b0; srd = '0; sd = '0;
        if (av) begin
            sv = 1'b1; srd = ar; sd = ad;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            sv = 1'b1; slsu = 1'b1; srd = e[36:32]; sd = e[31:0];
        end
        acc = lv && rdy;
        if (acc) mq.push_back({lr, ld});
        if (m_we && m_src_lsu) pend[m_addr] = 1'b0;
        if (iv && ir != 0) pend[ir] = 1'b1;
        m_we = sv && (srd != 0);
        m_src_lsu = sv && slsu;
        if (sv) begin
            m_addr = srd;
            m_data = sd;
        end
        if (m_we) expq.push_back({srd, sd});
        @(posedge clock);
    endtask

    task automatic idle(input int n, input logic [4:0] c1, input logic [4:0] c2);
        bit a;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, c1, c2, a);
    endtask

    initial begin
        bit a;
        int k;
        model_clear();

        // Reset state
        WB_check_addr1 = 5'd3; WB_check_addr2 = 5'd7;
        #2;
        chk("rst_we", {63'd0, REG_write_1}, 64'd0);
        chk("rst_addr", {59'd0, REG_address_wr}, 64'd0);
        chk("rst_data", {32'd0, REG_data_wb_in1}, 64'd0);
        chk("rst_ready", {63'd0, WB_lsu_ready}, 64'd0);
        chk("rst_busy1", {63'd0, WB_busy1}, 64'd0);
        chk("rst_busy2", {63'd0, WB_busy2}, 64'd0);
        @(posedge clock); @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);

        // ALU-only, including an rd=0 result that must not be written
        cyc(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, a);
        cyc(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, a);
        idle(3, 0, 0);

        // Load round-trip
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, a);
        idle(2, 7, 0);
        cyc(0, 0, 0, 1, 7, 32'hCAFE, 0, 0, 7, 0, a);
        idle(4, 7, 0);

        // Contention: ALU starves the FIFO until it fills
        k = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 5'd20 + 5'(i), 32'h100 + i, k < 4, 5'(k + 1), 32'hA0 + k, 0, 0, 0, 0, a);
            if (a) k++;
        end
        idle(6, 0, 0);

        // Wrap-around: ten back-to-back pushes
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 0, 1, 5'd10, 32'(i), 0, 0, 0, 0, a);
        idle(4, 0, 0);

        // Set-wins race on register 9
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, a);
        cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0, a);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, a);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, a);
        idle(3, 9, 0);
        cyc(0, 0, 0, 1, 9, 32'h9A, 0, 0, 9, 0, a);
        idle(4, 9, 0);

        // Async reset mid-stream: 3 buffered entries and rd=3 pending
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 3, 0, a);
        for (int i = 0; i < 3; i++)
            cyc(1, 5'd12, 32'h55 + i, 1, 5'd3, 32'h300 + i, 0, 0, 3, 0, a);
        #7;
        reset_n = 1'b0;
        WB_alu_valid = 0; WB_lsu_valid = 0; WB_issue_valid = 0;
        WB_check_addr1 = 5'd3; WB_check_addr2 = 5'd12;
        #1;
        chk("arst_we", {63'd0, REG_write_1}, 64'd0);
        chk("arst_addr", {59'd0, REG_address_wr}, 64'd0);
        chk("arst_data", {32'd0, REG_data_wb_in1}, 64'd0);
        chk("arst_ready", {63'd0, WB_lsu_ready}, 64'd0);
        chk("arst_busy1", {63'd0, WB_busy1}, 64'd0);
        model_clear();
        @(posedge clock); @(posedge clock); @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        idle(6, 3, 12);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 9) < 4, 5'($urandom), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
                $urandom_range(0, 4) == 0, 5'($urandom),
                5'($urandom), 5'($urandom), a);
        end
        idle(DEPTH + 4, 0, 0);
        chk("writes_outstanding", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
